// File: rtl/fiber_access_phase_ctrl.sv
// Phase sequencer for a fiber-access tile: forwards the write stream, then a gap, then the read stream.
// Only one of the write and read phases of a fiber is open at a time. Tiles repeat, and cycle counters are kept.
module fiber_access_phase_ctrl #(
    parameter int unsigned                DATA_WIDTH = 17,
    parameter logic [DATA_WIDTH-1:0]      DONE_TOKEN = 17'h10100,
    parameter int unsigned                CNT_WIDTH  = 32,
    parameter int unsigned                GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic                  clk_en,
    input  logic [GAP_WIDTH-1:0]  cfg_gap_cycles,
    input  logic [7:0]            cfg_num_tiles,
    input  logic [DATA_WIDTH-1:0] wr_in,
    input  logic                  wr_in_valid,
    output logic                  wr_in_ready,
    output logic [DATA_WIDTH-1:0] wr_out,
    output logic                  wr_out_valid,
    input  logic                  wr_out_ready,
    input  logic [DATA_WIDTH-1:0] rd_pos_in,
    input  logic                  rd_pos_in_valid,
    output logic                  rd_pos_in_ready,
    output logic [DATA_WIDTH-1:0] rd_pos_out,
    output logic                  rd_pos_out_valid,
    input  logic                  rd_pos_out_ready,
    input  logic [DATA_WIDTH-1:0] mon_coord,
    input  logic                  mon_coord_valid,
    input  logic                  mon_coord_ready,
    output logic [2:0]            state,
    output logic [7:0]            tile_idx,
    output logic                  tile_done,
    output logic                  all_done,
    output logic [CNT_WIDTH-1:0]  write_cycles,
    output logic [CNT_WIDTH-1:0]  read_cycles
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [GAP_WIDTH-1:0] gap_cnt;
    logic                 wr_open;
    logic                 rd_open;
    logic                 wr_hs;
    logic                 mon_hs;
    logic [7:0]           num_tiles_eff;
    logic [8:0]           next_idx;
    logic                 last_tile;

    // Streams are pure wires: a transfer happens when valid and ready are both
    // high in the same cycle, and the gate only masks valid/ready by phase.
    assign wr_open          = (state == ST_IDLE) || (state == ST_WRITE);
    assign rd_open          = (state == ST_READ);
    assign wr_out           = wr_in;
    assign wr_out_valid     = wr_in_valid & wr_open;
    assign wr_in_ready      = wr_out_ready & wr_open;
    assign rd_pos_out       = rd_pos_in;
    assign rd_pos_out_valid = rd_pos_in_valid & rd_open;
    assign rd_pos_in_ready  = rd_pos_out_ready & rd_open;

    assign wr_hs         = wr_in_valid & wr_in_ready;
    assign mon_hs        = mon_coord_valid & mon_coord_ready;
    assign num_tiles_eff = (cfg_num_tiles == 8'd0) ? 8'd1 : cfg_num_tiles;
    assign next_idx      = {1'b0, tile_idx} + 9'd1;
    assign last_tile     = next_idx >= {1'b0, num_tiles_eff};
    assign all_done      = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (flush) begin
            state        <= ST_IDLE;
            tile_idx     <= 8'd0;
            tile_done    <= 1'b0;
            gap_cnt      <= '0;
            write_cycles <= '0;
            read_cycles  <= '0;
        end else if (clk_en) begin
            tile_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A done token accepted here only opens the phase; it never closes it.
                    if (wr_in_valid) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_hs && (wr_in == DONE_TOKEN)) begin
                        state   <= ST_GAP;
                        gap_cnt <= cfg_gap_cycles;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                    else if (rd_pos_in_valid) state <= ST_READ;
                end
                ST_READ: begin
                    if (mon_hs && (mon_coord == DONE_TOKEN)) begin
                        tile_done <= 1'b1;
                        if (last_tile) begin
                            state <= ST_DONE;
                        end else begin
                            state    <= ST_IDLE;
                            tile_idx <= next_idx[7:0];
                        end
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase

            // Counters saturate so long runs read as "at least this many".
            if ((state == ST_WRITE) && (write_cycles != {CNT_WIDTH{1'b1}}))
                write_cycles <= write_cycles + 1'b1;
            if ((state == ST_READ) && (read_cycles != {CNT_WIDTH{1'b1}}))
                read_cycles <= read_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_fiber_access_phase_ctrl.sv
// Directed bench for fiber_access_phase_ctrl: phase gating, gap timing, tile sequencing, flush and clk_en.
module tb_fiber_access_phase_ctrl;

    localparam int          DW   = 17;
    localparam logic [16:0] DONE = 17'h10100;

    logic          clk = 1'b0;
    logic          flush, clk_en;
    logic [7:0]    cfg_gap_cycles, cfg_num_tiles;
    logic [DW-1:0] wr_in, wr_out, rd_pos_in, rd_pos_out, mon_coord;
    logic          wr_in_valid, wr_in_ready, wr_out_valid, wr_out_ready;
    logic          rd_pos_in_valid, rd_pos_in_ready, rd_pos_out_valid, rd_pos_out_ready;
    logic          mon_coord_valid, mon_coord_ready;
    logic [2:0]    state;
    logic [7:0]    tile_idx;
    logic          tile_done, all_done;
    logic [31:0]   write_cycles, read_cycles;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] wq[$];
    logic [DW-1:0] exp_q[$];
    int gap_len;

    fiber_access_phase_ctrl dut (
        .clk(clk), .flush(flush), .clk_en(clk_en),
        .cfg_gap_cycles(cfg_gap_cycles), .cfg_num_tiles(cfg_num_tiles),
        .wr_in(wr_in), .wr_in_valid(wr_in_valid), .wr_in_ready(wr_in_ready),
        .wr_out(wr_out), .wr_out_valid(wr_out_valid), .wr_out_ready(wr_out_ready),
        .rd_pos_in(rd_pos_in), .rd_pos_in_valid(rd_pos_in_valid), .rd_pos_in_ready(rd_pos_in_ready),
        .rd_pos_out(rd_pos_out), .rd_pos_out_valid(rd_pos_out_valid), .rd_pos_out_ready(rd_pos_out_ready),
        .mon_coord(mon_coord), .mon_coord_valid(mon_coord_valid), .mon_coord_ready(mon_coord_ready),
        .state(state), .tile_idx(tile_idx), .tile_done(tile_done), .all_done(all_done),
        .write_cycles(write_cycles), .read_cycles(read_cycles)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Fiber of n words: 1..n-1 followed by the done token.
    task automatic build(input int n);
        wq.delete();
        for (int i = 1; i < n; i++) wq.push_back(DW'(i));
        wq.push_back(DONE);
    endtask

    // Driver for the write stream; cycle 0 is the IDLE cycle.
    task automatic write_fiber(input logic idle_ready, input logic toggle);
        int c;
        int idx;
        c = 0;
        idx = 0;
        foreach (wq[i]) exp_q.push_back(wq[i]);
        while (idx < wq.size() && c < 60) begin
            wr_in_valid  = 1'b1;
            wr_in        = wq[idx];
            wr_out_ready = (c == 0) ? idle_ready : (toggle ? ((c % 2) == 1) : 1'b1);
            #1;
            chk("wr_ready_gate", wr_in_ready, wr_out_ready);
            chk("wr_valid_fwd", wr_out_valid, 1'b1);
            chk("rd_closed_in_write", rd_pos_out_valid, 1'b0);
            if (wr_out_valid && wr_out_ready) begin
                if (exp_q.size() == 0) chk("wr_extra_word", 1, 0);
                else chk("wr_data_order", wr_out, exp_q.pop_front());
            end
            if (wr_in_ready) idx++;
            tick();
            c++;
        end
        if (c >= 60) chk("wr_timeout", c, 0);
        wr_in_valid  = 1'b0;
        wr_out_ready = 1'b0;
        chk("wr_none_lost", exp_q.size(), 0);
        chk("state_gap_after_write", state, 3'd2);
    endtask

    // Counts cycles observed in GAP; rd_pos_in_valid rises after rd_delay cycles,
    // clk_en is low for observed cycles off_lo..off_hi.
    task automatic run_gap(input int rd_delay, input int off_lo, input int off_hi, output int n);
        n = 0;
        while (state == 3'd2 && n < 100) begin
            n++;
            clk_en           = !(n >= off_lo && n <= off_hi);
            rd_pos_in_valid  = (n > rd_delay);
            rd_pos_out_ready = 1'b1;
            rd_pos_in        = 17'h55;
            wr_in_valid      = 1'b1;
            wr_out_ready     = 1'b1;
            mon_coord        = DONE;
            mon_coord_valid  = 1'b1;
            mon_coord_ready  = 1'b1;
            #1;
            chk("gap_rd_ready", rd_pos_in_ready, 1'b0);
            chk("gap_rd_valid", rd_pos_out_valid, 1'b0);
            chk("gap_wr_ready", wr_in_ready, 1'b0);
            chk("gap_wr_valid", wr_out_valid, 1'b0);
            tick();
        end
        clk_en          = 1'b1;
        wr_in_valid     = 1'b0;
        wr_out_ready    = 1'b0;
        mon_coord_valid = 1'b0;
        mon_coord_ready = 1'b0;
    endtask

    // n READ cycles; the monitor done handshake lands on the last one.
    task automatic run_read(input int n);
        chk("state_read", state, 3'd3);
        for (int i = 1; i <= n; i++) begin
            rd_pos_in        = DW'(100 + i);
            rd_pos_in_valid  = 1'b1;
            rd_pos_out_ready = 1'b1;
            wr_in_valid      = 1'b1;
            mon_coord        = DONE;
            mon_coord_valid  = 1'b1;
            mon_coord_ready  = (i == n);
            #1;
            chk("rd_data_fwd", rd_pos_out, DW'(100 + i));
            chk("rd_valid_fwd", rd_pos_out_valid, 1'b1);
            chk("rd_ready_open", rd_pos_in_ready, 1'b1);
            chk("wr_closed_in_read", wr_in_ready, 1'b0);
            tick();
        end
        rd_pos_in_valid  = 1'b0;
        rd_pos_out_ready = 1'b0;
        wr_in_valid      = 1'b0;
        mon_coord_valid  = 1'b0;
        mon_coord_ready  = 1'b0;
    endtask

    initial begin
        flush = 1'b1; clk_en = 1'b1;
        cfg_gap_cycles = 8'd10; cfg_num_tiles = 8'd1;
        wr_in = '0; wr_in_valid = 1'b0; wr_out_ready = 1'b0;
        rd_pos_in = '0; rd_pos_in_valid = 1'b0; rd_pos_out_ready = 1'b0;
        mon_coord = '0; mon_coord_valid = 1'b0; mon_coord_ready = 1'b0;
        tick();
        tick();
        flush = 1'b0;
        #1;
        chk("rst_state", state, 3'd0);
        chk("rst_tile_idx", tile_idx, 8'd0);
        chk("rst_tile_done", tile_done, 1'b0);
        chk("rst_all_done", all_done, 1'b0);
        chk("rst_write_cycles", write_cycles, 32'd0);
        chk("rst_read_cycles", read_cycles, 32'd0);

        // 1: gap=10, one tile, 6 words, sink ready from the first WRITE cycle
        build(6);
        write_fiber(1'b0, 1'b0);
        chk("t1_write_cycles", write_cycles, 32'd6);
        run_gap(0, 0, -1, gap_len);
        chk("t1_gap_len", gap_len, 11);
        run_read(8);
        chk("t1_read_cycles", read_cycles, 32'd8);
        chk("t1_tile_done_pulse", tile_done, 1'b1);
        chk("t1_state_done", state, 3'd4);
        chk("t1_all_done", all_done, 1'b1);
        chk("t1_tile_idx_hold", tile_idx, 8'd0);
        tick();
        chk("t1_tile_done_clear", tile_done, 1'b0);
        chk("t1_all_done_hold", all_done, 1'b1);

        // 2: toggling backpressure, gap=2, read position late
        do_flush();
        cfg_gap_cycles = 8'd2;
        build(6);
        write_fiber(1'b0, 1'b1);
        chk("t2_write_cycles", write_cycles, 32'd11);
        run_gap(6, 0, -1, gap_len);
        chk("t2_gap_wait_valid", gap_len, 7);
        run_read(1);
        chk("t2_read_cycles", read_cycles, 32'd1);
        chk("t2_all_done", all_done, 1'b1);

        // 3: gap=0, tiles=0 (acts as 1), done token accepted in IDLE
        do_flush();
        cfg_gap_cycles = 8'd0;
        cfg_num_tiles  = 8'd0;
        rd_pos_in_valid = 1'b1;
        wq.delete();
        wq.push_back(DONE);
        wq.push_back(17'h7);
        wq.push_back(DONE);
        write_fiber(1'b1, 1'b0);
        chk("t3_write_cycles", write_cycles, 32'd2);
        run_gap(0, 0, -1, gap_len);
        chk("t3_gap_one_cycle", gap_len, 1);
        run_read(1);
        chk("t3_zero_tiles_done", state, 3'd4);
        wr_in_valid = 1'b1;
        wr_out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("t3_done_terminal", state, 3'd4);
        chk("t3_done_wr_closed", wr_in_ready, 1'b0);
        wr_in_valid = 1'b0;
        wr_out_ready = 1'b0;

        // 4: three tiles, gap=1
        do_flush();
        cfg_gap_cycles = 8'd1;
        cfg_num_tiles  = 8'd3;
        for (int t = 0; t < 3; t++) begin
            chk("t4_tile_idx", tile_idx, t);
            build(3);
            write_fiber(1'b0, 1'b0);
            run_gap(0, 0, -1, gap_len);
            chk("t4_gap_len", gap_len, 2);
            run_read(2);
            chk("t4_tile_done", tile_done, 1'b1);
            if (t < 2) begin
                chk("t4_back_to_idle", state, 3'd0);
                chk("t4_tile_idx_step", tile_idx, t + 1);
                chk("t4_not_all_done", all_done, 1'b0);
            end else begin
                chk("t4_state_done", state, 3'd4);
                chk("t4_tile_idx_final", tile_idx, 8'd2);
            end
            tick();
            chk("t4_tile_done_clear", tile_done, 1'b0);
        end
        chk("t4_write_sum", write_cycles, 32'd9);
        chk("t4_read_sum", read_cycles, 32'd6);

        // 5: flush in the middle of READ, with clk_en low
        do_flush();
        cfg_gap_cycles = 8'd0;
        cfg_num_tiles  = 8'd1;
        build(2);
        write_fiber(1'b0, 1'b0);
        run_gap(0, 0, -1, gap_len);
        chk("t5_state_read", state, 3'd3);
        rd_pos_in_valid  = 1'b1;
        rd_pos_out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_read_cycles", read_cycles, 32'd3);
        flush  = 1'b1;
        clk_en = 1'b0;
        tick();
        flush  = 1'b0;
        clk_en = 1'b1;
        #1;
        chk("t5_flush_state", state, 3'd0);
        chk("t5_flush_wr_cnt", write_cycles, 32'd0);
        chk("t5_flush_rd_cnt", read_cycles, 32'd0);
        chk("t5_flush_rd_ready", rd_pos_in_ready, 1'b0);
        rd_pos_in_valid  = 1'b0;
        rd_pos_out_ready = 1'b0;

        // 6: gap=5 with clk_en low for 4 GAP cycles, then a READ freeze
        cfg_gap_cycles = 8'd5;
        build(2);
        write_fiber(1'b0, 1'b0);
        chk("t6_write_cycles", write_cycles, 32'd2);
        run_gap(0, 3, 6, gap_len);
        chk("t6_gap_extended", gap_len, 10);
        chk("t6_read_cycles_held", read_cycles, 32'd0);
        rd_pos_in_valid  = 1'b1;
        rd_pos_out_ready = 1'b1;
        tick();
        chk("t6_read_one", read_cycles, 32'd1);
        clk_en          = 1'b0;
        mon_coord       = DONE;
        mon_coord_valid = 1'b1;
        mon_coord_ready = 1'b1;
        tick();
        tick();
        chk("t6_freeze_state", state, 3'd3);
        chk("t6_freeze_read_cnt", read_cycles, 32'd1);
        chk("t6_freeze_rd_ready", rd_pos_in_ready, 1'b1);
        clk_en          = 1'b1;
        mon_coord_valid = 1'b0;
        mon_coord_ready = 1'b0;
        run_read(1);
        chk("t6_read_total", read_cycles, 32'd2);
        chk("t6_all_done", all_done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
